// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial a - b - borrow_i through one shared 1-bit subtractor cell, LSB first.
// Optional macro SERIAL_SUB_SAT_EN: clamp diff_o to zero when the final borrow is set.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             borrow_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             busy_o
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One full-subtractor cell; result packed as {borrow_out, diff}.
    function automatic logic [1:0] sub_cell(input logic a, input logic b, input logic bin);
        sub_cell = {(~a & b) | (~a & bin) | (b & bin), a ^ b ^ bin};
    endfunction

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-2:0]   res_sh_r;
    logic               brw_r;

    logic [1:0]         cell_s;
    logic [WIDTH-1:0]   next_res_s;
    logic [WIDTH-1:0]   final_diff_s;

    // Cell evaluation for the current bit and the result word once this bit lands at the MSB.
    always_comb begin
        cell_s     = sub_cell(a_sh_r[0], b_sh_r[0], brw_r);
        next_res_s = {cell_s[0], res_sh_r};
`ifdef SERIAL_SUB_SAT_EN
        if (cell_s[1]) begin
            final_diff_s = {WIDTH{1'b0}};
        end else begin
            final_diff_s = next_res_s;
        end
`else
        final_diff_s = next_res_s;
`endif
    end

    // Sequencer: load operands, step one bit per cycle, then hold the result until taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            a_sh_r      <= {WIDTH{1'b0}};
            b_sh_r      <= {WIDTH{1'b0}};
            res_sh_r    <= {(WIDTH-1){1'b0}};
            brw_r       <= 1'b0;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            diff_o      <= {WIDTH{1'b0}};
            borrow_o    <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid_i && in_ready_o) begin
                        a_sh_r     <= a_i;
                        b_sh_r     <= b_i;
                        brw_r      <= borrow_i;
                        cnt_r      <= {CNT_W{1'b0}};
                        in_ready_o <= 1'b0;
                        busy_o     <= 1'b1;
                        state_r    <= RUN;
                    end
                end
                RUN: begin
                    a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                    res_sh_r <= next_res_s[WIDTH-1:1];
                    brw_r    <= cell_s[1];
                    cnt_r    <= cnt_r + CNT_W'(1);
                    // The MSB step publishes the result; the counter wrap at 2^k widths is harmless here.
                    if (cnt_r == LAST_BIT) begin
                        diff_o      <= final_diff_s;
                        borrow_o    <= cell_s[1];
                        out_valid_o <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        busy_o      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_o  <= 1'b1;
                    out_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: cycle model for WIDTH=8, result scoreboard for WIDTH=16.
module tb_serial_sub_ctrl;
    localparam int W  = 8;
    localparam int W2 = 16;
`ifdef SERIAL_SUB_SAT_EN
    localparam logic [7:0] EXP_5_9 = 8'd0;
    localparam logic [7:0] EXP_0_0 = 8'd0;
`else
    localparam logic [7:0] EXP_5_9 = 8'd252;
    localparam logic [7:0] EXP_0_0 = 8'd255;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_valid, in_ready, borrow_in, out_valid, out_ready, borrow_out, busy;
    logic [W-1:0] a, b, diff;
    logic rst2, in_valid2, in_ready2, borrow_in2, out_valid2, out_ready2, borrow_out2, busy2;
    logic [W2-1:0] a2, b2, diff2;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic chk_en = 1'b0;
    logic done8 = 1'b0, done16 = 1'b0;
    logic sp8_en = 1'b0, sp16_en = 1'b0;
    int last_acc8 = -1, last_acc16 = -1, n_sp8 = 0, n_sp16 = 0;
    int n_acc16 = 0, n_res16 = 0;
    logic [16:0] q16[$];
    logic [16:0] e16;

    serial_sub_ctrl #(.WIDTH(W)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .borrow_i(borrow_in), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .diff_o(diff), .borrow_o(borrow_out), .busy_o(busy)
    );

    serial_sub_ctrl #(.WIDTH(W2)) u_dut16 (
        .clk_i(clk), .rst_i(rst2), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
        .a_i(a2), .b_i(b2), .borrow_i(borrow_in2), .out_valid_o(out_valid2),
        .out_ready_i(out_ready2), .diff_o(diff2), .borrow_o(borrow_out2), .busy_o(busy2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference subtraction: {borrow, diff[15:0]} for a w-bit operation.
    function automatic logic [16:0] ref_sub(input int unsigned aa, input int unsigned bb,
                                            input int unsigned cin, input int unsigned w);
        int unsigned m = 32'd1 << w;
        int unsigned d = (aa + m - bb - cin) % m;
        logic bo = (aa < bb + cin);
`ifdef SERIAL_SUB_SAT_EN
        if (bo) d = 32'd0;
`endif
        return {bo, d[15:0]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Cycle model of the WIDTH=8 block: idle -> W compute cycles -> result held until taken.
    int m_phase = 0, m_left = 0;
    logic m_ready = 1'b1, m_valid = 1'b0, m_busy = 1'b0, m_borrow = 1'b0;
    logic [W-1:0] m_diff = '0;
    logic [16:0] m_pend = '0;
    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0; m_ready <= 1'b1; m_valid <= 1'b0; m_busy <= 1'b0;
            m_diff <= '0; m_borrow <= 1'b0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_phase <= 1; m_left <= W; m_ready <= 1'b0; m_busy <= 1'b1;
                m_pend <= ref_sub(32'(a), 32'(b), 32'(borrow_in), W);
            end
        end else if (m_phase == 1) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_phase <= 2; m_valid <= 1'b1;
                m_diff <= m_pend[W-1:0]; m_borrow <= m_pend[16];
            end
        end else if (out_ready) begin
            m_phase <= 0; m_valid <= 1'b0; m_ready <= 1'b1; m_busy <= 1'b0;
        end
    end

    // Every-cycle comparison of the WIDTH=8 DUT against the model, plus accept spacing.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_in_ready", 64'(in_ready), 64'(m_ready));
            check("model_out_valid", 64'(out_valid), 64'(m_valid));
            check("model_busy", 64'(busy), 64'(m_busy));
            check("model_diff", 64'(diff), 64'(m_diff));
            check("model_borrow", 64'(borrow_out), 64'(m_borrow));
            if (!sp8_en) last_acc8 <= -1;
            else if (!rst && in_valid && in_ready) begin
                if (last_acc8 >= 0) begin
                    check("spacing8", 64'(cyc - last_acc8), 64'(W + 2));
                    n_sp8 <= n_sp8 + 1;
                end
                last_acc8 <= cyc;
            end
        end
    end

    // WIDTH=16 scoreboard: push expected on accept, compare on handoff.
    always @(negedge clk) begin
        if (!rst2 && in_valid2 && in_ready2) begin
            q16.push_back(ref_sub(32'(a2), 32'(b2), 32'(borrow_in2), W2));
            n_acc16 <= n_acc16 + 1;
            if (sp16_en) begin
                if (last_acc16 >= 0) begin
                    check("spacing16", 64'(cyc - last_acc16), 64'(W2 + 2));
                    n_sp16 <= n_sp16 + 1;
                end
                last_acc16 <= cyc;
            end
        end
        if (!sp16_en) last_acc16 <= -1;
        if (!rst2 && out_valid2 && out_ready2) begin
            n_res16 <= n_res16 + 1;
            total++;
            if (q16.size() == 0) begin
                bad++;
                $display("FAIL sb16_extra: got unexpected result %0d expected none", diff2);
            end else begin
                e16 = q16.pop_front();
                check("sb16_diff", 64'(diff2), 64'(e16[15:0]));
                check("sb16_borrow", 64'(borrow_out2), 64'(e16[16]));
            end
        end
    end

    task automatic run_op(input string name, input logic [7:0] aa, input logic [7:0] bb,
                          input logic cin, input int hold,
                          input logic [7:0] exp_d, input logic exp_b);
        int n = 0;
        int lat;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        a = aa; b = bb; borrow_in = cin; in_valid = 1'b1; out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        check({name, "_latency"}, 64'(lat), 64'(W + 1));
        check({name, "_diff"}, 64'(diff), 64'(exp_d));
        check({name, "_borrow"}, 64'(borrow_out), 64'(exp_b));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = ~aa;
            @(posedge clk); #1;
            check({name, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({name, "_hold_diff"}, 64'(diff), 64'(exp_d));
            check({name, "_hold_borrow"}, 64'(borrow_out), 64'(exp_b));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check({name, "_ready_back"}, 64'(in_ready), 64'd1);
        check({name, "_valid_drop"}, 64'(out_valid), 64'd0);
    endtask

    // WIDTH=8: reset, directed vectors, mid-run reset, random back-to-back, spacing.
    initial begin
        int acc, guard;
        rst = 1'b1; in_valid = 1'b1; a = 8'd7; b = 8'd1; borrow_in = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_diff", 64'(diff), 64'd0);
        check("rst_borrow", 64'(borrow_out), 64'd0);
        rst = 1'b0;

        run_op("v200_55", 8'd200, 8'd55, 1'b0, 0, 8'd145, 1'b0);
        run_op("v5_9", 8'd5, 8'd9, 1'b0, 0, EXP_5_9, 1'b1);
        run_op("v0_0_c1", 8'd0, 8'd0, 1'b1, 0, EXP_0_0, 1'b1);
        run_op("chain", 8'h34, 8'h12, 1'b1, 3, 8'h21, 1'b0);

        a = 8'd200; b = 8'd55; borrow_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("midrst_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_diff", 64'(diff), 64'd0);
        check("midrst_borrow", 64'(borrow_out), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            check("midrst_no_result", 64'(out_valid), 64'd0);
        end

        acc = 0; guard = 0;
        while (acc < 1000 && guard < 40000) begin
            a = 8'($urandom); b = 8'($urandom); borrow_in = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1)); in_valid = 1'b1;
            if (in_ready) acc++;
            @(posedge clk); #1;
            guard++;
        end
        check("rand8_accepts", 64'(acc), 64'd1000);

        out_ready = 1'b1;
        while (!in_ready && guard < 40100) begin @(posedge clk); #1; guard++; end
        sp8_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = 8'($urandom); b = 8'($urandom); borrow_in = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0; sp8_en = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        check("spacing8_seen", 64'(n_sp8 >= 4), 64'd1);
        done8 = 1'b1;
    end

    // WIDTH=16: random back-to-back with scoreboard, then constant-ready spacing and drain.
    initial begin
        int acc, guard;
        rst2 = 1'b1; in_valid2 = 1'b0; a2 = '0; b2 = '0; borrow_in2 = 1'b0; out_ready2 = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst2 = 1'b0;
        acc = 0; guard = 0;
        while (acc < 1000 && guard < 60000) begin
            a2 = 16'($urandom); b2 = 16'($urandom); borrow_in2 = 1'($urandom_range(0, 1));
            out_ready2 = 1'($urandom_range(0, 1)); in_valid2 = 1'b1;
            if (in_ready2) acc++;
            @(posedge clk); #1;
            guard++;
        end
        check("rand16_accepts", 64'(acc), 64'd1000);
        out_ready2 = 1'b1;
        while (!in_ready2 && guard < 60100) begin @(posedge clk); #1; guard++; end
        sp16_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a2 = 16'($urandom); b2 = 16'($urandom); borrow_in2 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid2 = 1'b0; sp16_en = 1'b0;
        guard = 0;
        while (busy2 && guard < 100) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        check("drain16_idle", 64'(busy2), 64'd0);
        check("drain16_queue", 64'(q16.size()), 64'd0);
        check("results16", 64'(n_res16), 64'(n_acc16));
        check("spacing16_seen", 64'(n_sp16 >= 4), 64'd1);
        done16 = 1'b1;
    end

    initial begin
        wait (done8 && done16);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
